// File: rtl/babbage_inverse_if.sv
// rtl/babbage_inverse_if.sv - start/rdy/done handshake and result bundle for babbage_inverse
interface babbage_inverse_if #(
  parameter int IN_WIDTH = 5
) ();
  localparam int OUT_WIDTH = 2 * IN_WIDTH + 2;

  logic                 start;
  logic [OUT_WIDTH-1:0] y;
  logic [IN_WIDTH-1:0]  n_out;
  logic                 exact;
  logic                 under;
  logic                 sat;
  logic                 done;
  logic                 rdy;

  modport master (
    output start, y,
    input  n_out, exact, under, sat, done, rdy
  );

  modport slave (
    input  start, y,
    output n_out, exact, under, sat, done, rdy
  );
endinterface

// File: rtl/babbage_inverse.sv
// rtl/babbage_inverse.sv - largest n with 2n^2+3n+5 <= y, found by forward differences
module babbage_inverse #(
  parameter int IN_WIDTH = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  babbage_inverse_if.slave  bus
);
  localparam int OUT_WIDTH = 2 * IN_WIDTH + 2;
  localparam logic [IN_WIDTH-1:0]  NMAX  = '1;
  localparam logic [OUT_WIDTH-1:0] F0    = OUT_WIDTH'(5);
  localparam logic [OUT_WIDTH-1:0] G0    = OUT_WIDTH'(5);
  localparam logic [OUT_WIDTH-1:0] DIFF2 = OUT_WIDTH'(4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SRCH = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [OUT_WIDTH-1:0] f;
  logic [OUT_WIDTH-1:0] g;
  logic [IN_WIDTH-1:0]  k;
  logic [OUT_WIDTH-1:0] y_reg;
  logic [IN_WIDTH-1:0]  n_out_r;
  logic                 exact_r;
  logic                 under_r;
  logic                 sat_r;
  logic [OUT_WIDTH:0]   next_f;

  // One extra bit so f+g can never wrap below y_reg and end the search early.
  assign next_f = {1'b0, f} + {1'b0, g};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= S_IDLE;
      f       <= '0;
      g       <= '0;
      k       <= '0;
      y_reg   <= '0;
      n_out_r <= '0;
      exact_r <= 1'b0;
      under_r <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.y < F0) begin
              n_out_r <= '0;
              under_r <= 1'b1;
              exact_r <= 1'b0;
              sat_r   <= 1'b0;
              state   <= S_DONE;
            end else begin
              y_reg <= bus.y;
              f     <= F0;
              g     <= G0;
              k     <= '0;
              state <= S_SRCH;
            end
          end
        end
        S_SRCH: begin
          if (k == NMAX) begin
            n_out_r <= NMAX;
            exact_r <= (f == y_reg);
            sat_r   <= (f < y_reg);
            under_r <= 1'b0;
            state   <= S_DONE;
          end else if (next_f > {1'b0, y_reg}) begin
            n_out_r <= k;
            exact_r <= (f == y_reg);
            sat_r   <= 1'b0;
            under_r <= 1'b0;
            state   <= S_DONE;
          end else begin
            f <= next_f[OUT_WIDTH-1:0];
            g <= g + DIFF2;
            k <= k + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.n_out = n_out_r;
  assign bus.exact = exact_r;
  assign bus.under = under_r;
  assign bus.sat   = sat_r;
  assign bus.done  = (state == S_DONE);
  assign bus.rdy   = (state == S_IDLE);
endmodule

// File: tb/tb_babbage_inverse.sv
// tb/tb_babbage_inverse.sv - randomized and directed checks of babbage_inverse against an arithmetic model
module tb_babbage_inverse;
  localparam int IN_WIDTH  = 5;
  localparam int OUT_WIDTH = 2 * IN_WIDTH + 2;
  localparam int NMAX      = (1 << IN_WIDTH) - 1;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  babbage_inverse_if #(.IN_WIDTH(IN_WIDTH)) bus ();

  babbage_inverse #(.IN_WIDTH(IN_WIDTH)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic int fpoly(input int n);
    return 2 * n * n + 3 * n + 5;
  endfunction

  task automatic model(input int yv, output int n, output int ex, output int un, output int sa);
    n = 0; ex = 0; un = 0; sa = 0;
    if (yv < fpoly(0)) begin
      un = 1;
    end else begin
      for (int m = 0; m <= NMAX; m++)
        if (fpoly(m) <= yv) n = m;
      ex = (fpoly(n) == yv) ? 1 : 0;
      sa = (yv > fpoly(NMAX)) ? 1 : 0;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_y(input int yv, input string tag);
    int lat, rdy_bad, en, ex, un, sa;
    model(yv, en, ex, un, sa);
    bus.y = OUT_WIDTH'(yv);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.y = OUT_WIDTH'($urandom);
    lat = 1;
    rdy_bad = 0;
    while (!bus.done && lat < 100) begin
      if (bus.rdy) rdy_bad++;
      step();
      lat++;
    end
    check({tag, " latency"}, lat, un ? 1 : en + 2);
    check({tag, " n_out"}, int'(bus.n_out), en);
    check({tag, " exact"}, int'(bus.exact), ex);
    check({tag, " under"}, int'(bus.under), un);
    check({tag, " sat"}, int'(bus.sat), sa);
    check({tag, " rdy low while busy"}, rdy_bad, 0);
    step();
    check({tag, " done one cycle"}, int'(bus.done), 0);
    check({tag, " rdy after done"}, int'(bus.rdy), 1);
  endtask

  initial begin
    int lat, bad, en, ex, un, sa;
    bus.start = 1'b0;
    bus.y = '0;
    #12;
    check("reset rdy", int'(bus.rdy), 1);
    check("reset done", int'(bus.done), 0);
    check("reset n_out", int'(bus.n_out), 0);
    check("reset flags", int'({bus.exact, bus.under, bus.sat}), 0);
    arst_n = 1'b1;
    step();

    run_y(32, "y32");
    run_y(33, "y33");
    run_y(48, "y48");
    run_y(49, "y49");
    run_y(4, "y4");
    run_y(5, "y5");
    run_y(2020, "y2020");
    run_y(4095, "y4095");
    run_y(0, "y0");

    // start held high while y toggles; only the captured value matters
    bus.y = OUT_WIDTH'(10);
    bus.start = 1'b1;
    step();
    lat = 1;
    while (!bus.done && lat < 100) begin
      bus.y = (bus.y == OUT_WIDTH'(10)) ? OUT_WIDTH'(4000) : OUT_WIDTH'(10);
      step();
      lat++;
    end
    check("held latency", lat, 3);
    check("held n_out", int'(bus.n_out), 1);
    check("held exact", int'(bus.exact), 1);
    bus.y = OUT_WIDTH'(4000);
    step();
    check("held rdy after done", int'(bus.rdy), 1);
    step();
    bus.start = 1'b0;
    check("held second accepted", int'(bus.rdy), 0);
    lat = 1;
    bad = 0;
    while (!bus.done && lat < 100) begin
      if (bus.n_out != 1 || bus.exact != 1'b1 || bus.sat != 1'b0) bad++;
      step();
      lat++;
    end
    check("held outputs stable", bad, 0);
    check("second latency", lat, 33);
    check("second n_out", int'(bus.n_out), 31);
    check("second sat", int'(bus.sat), 1);
    step();

    // reset in the middle of a search
    bus.y = OUT_WIDTH'(2020);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    arst_n = 1'b0;
    #1;
    check("midreset rdy", int'(bus.rdy), 1);
    check("midreset done", int'(bus.done), 0);
    check("midreset outputs", int'({bus.n_out, bus.exact, bus.under, bus.sat}), 0);
    #2;
    arst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      step();
      if (bus.done) bad++;
    end
    check("midreset no done", bad, 0);
    run_y(19, "y19 after reset");

    for (int m = 0; m <= NMAX; m++)
      run_y(fpoly(m), $sformatf("sweep m=%0d", m));

    for (int i = 0; i < 25; i++) begin
      int r;
      r = (i < 8) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, (1 << OUT_WIDTH) - 1));
      run_y(r, $sformatf("rand y=%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
